// File: rtl/regfile_alu_seq.sv
// Four-register execution unit: serial operand fetch through one read mux, ALU, write-back.
// Optional flag outputs (oZero, oCarry) are compiled in with `define REGFILE_ALU_FLAGS_EN.
module regfile_alu_seq #(
    parameter int N = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         iLoad,
    input  logic [1:0]   iIndex,
    input  logic [N-1:0] iData,
    input  logic         iStart,
    input  logic [1:0]   iOp,
    input  logic [1:0]   iRd,
    input  logic [1:0]   iRs,
    input  logic [1:0]   iRt,
    output logic         oBusy,
    output logic         oDone,
    output logic [2:0]   oState,
    output logic [N-1:0] oR0,
    output logic [N-1:0] oR1,
    output logic [N-1:0] oR2,
    output logic [N-1:0] oR3,
    output logic [N-1:0] oQ
`ifdef REGFILE_ALU_FLAGS_EN
    ,
    output logic         oZero,
    output logic         oCarry
`endif
);

    // state | meaning
    // IDLE  | waiting; external loads and instruction start accepted
    // RDA   | read mux on latched Rs, capture operand A
    // RDB   | read mux on latched Rt, capture operand B
    // EXE   | result <= A op B
    // WB    | Rd <= result, done pulse follows
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        EXE  = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    state_t       state, state_next;
    logic [N-1:0] regs [4];
    logic [1:0]   ir_op, ir_rd, ir_rs, ir_rt;
    logic [N-1:0] opa, opb, result;
    logic         done;
    logic [1:0]   rd_sel;
    logic [N-1:0] rd_val;
    logic [N-1:0] alu_res;
`ifdef REGFILE_ALU_FLAGS_EN
    logic         alu_carry;
    logic         res_carry;
    logic         zero_q, carry_q;
`endif

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = iStart ? RDA : IDLE;
            RDA:     state_next = RDB;
            RDB:     state_next = EXE;
            EXE:     state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The single operand read port: Rs during RDA, Rt during RDB.
    always_comb begin
        rd_sel = (state == RDB) ? ir_rt : ir_rs;
        rd_val = regs[rd_sel];
    end

    always_comb begin
        alu_res = '0;
        case (ir_op)
            OP_ADD: alu_res = opa + opb;
            OP_SUB: alu_res = opa - opb;
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            default: alu_res = '0;
        endcase
    end

`ifdef REGFILE_ALU_FLAGS_EN
    // a + b overflows exactly when a > ~b; subtraction borrows when a < b.
    always_comb begin
        alu_carry = 1'b0;
        case (ir_op)
            OP_ADD:  alu_carry = (opa > ~opb);
            OP_SUB:  alu_carry = (opa < opb);
            default: alu_carry = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            regs   <= '{default: '0};
            ir_op  <= '0;
            ir_rd  <= '0;
            ir_rs  <= '0;
            ir_rt  <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == WB);
            case (state)
                IDLE: begin
                    if (iLoad)
                        regs[iIndex] <= iData;
                    if (iStart) begin
                        ir_op <= iOp;
                        ir_rd <= iRd;
                        ir_rs <= iRs;
                        ir_rt <= iRt;
                    end
                end
                RDA:     opa <= rd_val;
                RDB:     opb <= rd_val;
                EXE:     result <= alu_res;
                WB:      regs[ir_rd] <= result;
                default: ;
            endcase
        end
    end

`ifdef REGFILE_ALU_FLAGS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            res_carry <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            if (state == EXE)
                res_carry <= alu_carry;
            if (state == WB) begin
                zero_q  <= (result == '0);
                carry_q <= res_carry;
            end
        end
    end

    assign oZero  = zero_q;
    assign oCarry = carry_q;
`endif

    assign oBusy  = (state != IDLE);
    assign oDone  = done;
    assign oState = state;
    assign oR0    = regs[0];
    assign oR1    = regs[1];
    assign oR2    = regs[2];
    assign oR3    = regs[3];
    assign oQ     = regs[iIndex];

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Scoreboard bench for regfile_alu_seq: expected write-backs queued at issue, checked on oDone.
// Flag checks are active when REGFILE_ALU_FLAGS_EN is defined.
module tb_regfile_alu_seq;

    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         iLoad = 1'b0;
    logic [1:0]   iIndex = '0;
    logic [N-1:0] iData = '0;
    logic         iStart = 1'b0;
    logic [1:0]   iOp = '0;
    logic [1:0]   iRd = '0, iRs = '0, iRt = '0;
    logic         oBusy, oDone;
    logic [2:0]   oState;
    logic [N-1:0] oR0, oR1, oR2, oR3, oQ;
`ifdef REGFILE_ALU_FLAGS_EN
    logic         oZero, oCarry;
`endif

    regfile_alu_seq #(.N(N)) dut (
        .Clk(Clk), .Reset(Reset), .iLoad(iLoad), .iIndex(iIndex), .iData(iData),
        .iStart(iStart), .iOp(iOp), .iRd(iRd), .iRs(iRs), .iRt(iRt),
        .oBusy(oBusy), .oDone(oDone), .oState(oState),
        .oR0(oR0), .oR1(oR1), .oR2(oR2), .oR3(oR3), .oQ(oQ)
`ifdef REGFILE_ALU_FLAGS_EN
        , .oZero(oZero), .oCarry(oCarry)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]   rd;
        logic [N-1:0] val;
        logic         c;
        logic         z;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] model [4];
    int           checks = 0;
    int           errors = 0;
    int           done_count = 0;
    int           exp_dones = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] get_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    return oR0;
            2'd1:    return oR1;
            2'd2:    return oR2;
            default: return oR3;
        endcase
    endfunction

    // Monitor: every oDone pulse must match the oldest queued write-back.
    always @(negedge Clk) begin
        if (!Reset && oDone) begin
            done_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done with empty scoreboard");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_value", get_reg(e.rd), e.val);
`ifdef REGFILE_ALU_FLAGS_EN
                check("carry", oCarry, e.c);
                check("zero", oZero, e.z);
`endif
            end
        end
    end

    task automatic check_regs(input string tag);
        check({tag, "_r0"}, oR0, model[0]);
        check({tag, "_r1"}, oR1, model[1]);
        check({tag, "_r2"}, oR2, model[2]);
        check({tag, "_r3"}, oR3, model[3]);
        for (int i = 0; i < 4; i++) begin
            iIndex = 2'(i);
            #1;
            check({tag, "_oq"}, oQ, model[i]);
        end
    endtask

    task automatic load(input logic [1:0] idx, input logic [N-1:0] d);
        @(negedge Clk);
        iLoad = 1'b1; iIndex = idx; iData = d;
        @(negedge Clk);
        iLoad = 1'b0;
        model[idx] = d;
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        while (oBusy && busy < 10) begin
            busy++;
            @(negedge Clk);
        end
    endtask

    task automatic run_instr(input logic [1:0] op, rd, rs, rt, input logic [N-1:0] val,
                             input logic c, z, input logic ld, input logic [1:0] ld_idx,
                             input logic [N-1:0] ld_d);
        int busy;
        @(negedge Clk);
        iStart = 1'b1; iOp = op; iRd = rd; iRs = rs; iRt = rt;
        iLoad = ld; iIndex = ld_idx; iData = ld_d;
        sb_q.push_back('{rd, val, c, z});
        exp_dones++;
        if (ld) model[ld_idx] = ld_d;
        @(negedge Clk);
        iStart = 1'b0; iLoad = 1'b0;
        wait_idle(busy);
        check("busy_cycles", busy, 4);
        model[rd] = val;
        check_regs("after_instr");
    endtask

    initial begin
        int busy;
        for (int i = 0; i < 4; i++) model[i] = '0;
        #1;
        check("rst_state", oState, 0);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check_regs("rst");
        @(negedge Clk);
        Reset = 1'b0;

        // Reset in the middle of RDB aborts without write-back.
        load(2'd1, 4'h3);
        load(2'd2, 4'h5);
        @(negedge Clk);
        iStart = 1'b1; iOp = 2'b00; iRd = 2'd3; iRs = 2'd1; iRt = 2'd2;
        @(negedge Clk);
        iStart = 1'b0;
        @(negedge Clk);
        check("mid_state_rdb", oState, 2);
        #2 Reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        check("abort_state", oState, 0);
        check("abort_busy", oBusy, 0);
        check_regs("abort");
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check("abort_no_done", done_count, 0);

        load(2'd1, 4'h3);
        load(2'd2, 4'h5);
        run_instr(2'b00, 2'd3, 2'd1, 2'd2, 4'h8, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);

        load(2'd0, 4'h2);
        load(2'd1, 4'h5);
        run_instr(2'b01, 2'd0, 2'd0, 2'd1, 4'hD, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);

        load(2'd2, 4'hF);
        run_instr(2'b00, 2'd2, 2'd2, 2'd2, 4'hE, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
        run_instr(2'b10, 2'd1, 2'd2, 2'd2, 4'hE, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        run_instr(2'b01, 2'd2, 2'd3, 2'd3, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0);

        // OR R3 = R0|R1 = D|E while start/load/fields are wiggled mid-flight.
        @(negedge Clk);
        iStart = 1'b1; iOp = 2'b11; iRd = 2'd3; iRs = 2'd0; iRt = 2'd1;
        sb_q.push_back('{2'd3, 4'hF, 1'b0, 1'b0});
        exp_dones++;
        @(negedge Clk);
        iOp = 2'b00; iRd = 2'd0; iRs = 2'd2; iRt = 2'd2;
        iLoad = 1'b1; iIndex = 2'd0; iData = 4'h9;
        @(negedge Clk);
        @(negedge Clk);
        iStart = 1'b0; iLoad = 1'b0;
        wait_idle(busy);
        check("busy_or_run", busy, 2);
        repeat (6) @(negedge Clk);
        model[3] = 4'hF;
        check_regs("ignored_start");

        // Load R1=7 together with start of OR R0 = R1|R1.
        run_instr(2'b11, 2'd0, 2'd1, 2'd1, 4'h7, 1'b0, 1'b0, 1'b1, 2'd1, 4'h7);

        repeat (3) @(negedge Clk);
        check("done_pulses", done_count, exp_dones);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
